// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, defaults and pointer-width helper
package uart_pkg;

    localparam int DATA_BITS_DEF = 8;
    localparam int DEPTH_DEF     = 16;
    localparam int ptr_w         = $clog2(DEPTH_DEF);

    // Layout shared with the APB status register: framing error above the character.
    typedef struct packed {
        logic                     err;
        logic [DATA_BITS_DEF-1:0] data;
    } rx_entry_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - simple dual-port array, synchronous write, asynchronous read
module uart_fifo_mem #(
    parameter int WIDTH  = 9,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead RX character FIFO with level, overrun and error counting
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int THRESH    = 8
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic                       rx_rst,
    input  logic                       wr_valid,
    input  logic [DATA_BITS-1:0]       wr_data,
    input  logic                       wr_err,
    input  logic                       rd_en,
    output logic [DATA_BITS-1:0]       rd_data,
    output logic                       rd_err,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       thresh_irq,
    output logic                       overrun,
    input  logic                       ovr_clr,
    output logic [7:0]                 err_cnt,
    input  logic                       err_clr
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] THRESH_L = LVL_W'(THRESH);

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [DATA_BITS:0] head;
    logic               do_push;
    logic               do_pop;
    logic               ovr_set;

    assign empty      = (level == '0);
    assign full       = (level == DEPTH_L);
    assign thresh_irq = (level >= THRESH_L);

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = wr_valid && (!full || rd_en);
    assign do_pop  = rd_en && !empty;
    assign ovr_set = wr_valid && full && !rd_en;

    uart_fifo_mem #(
        .WIDTH  (DATA_BITS + 1),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (PCLK),
        .wr_en   (do_push && !rx_rst),
        .wr_addr (wr_ptr),
        .wr_data ({wr_err, wr_data}),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    assign rd_data = empty ? '0 : head[DATA_BITS-1:0];
    assign rd_err  = empty ? 1'b0 : head[DATA_BITS];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
            err_cnt <= '0;
        end else if (rx_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end

            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end

            // An accepted error push beats a simultaneous clear, restarting the count at 1.
            if (do_push && wr_err) begin
                if (err_clr) begin
                    err_cnt <= 8'd1;
                end else if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end else if (err_clr) begin
                err_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       rx_rst;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_err;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_err;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       thresh_irq;
    logic       overrun;
    logic       ovr_clr;
    logic [7:0] err_cnt;
    logic       err_clr;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DATA_BITS(8), .DEPTH(16), .THRESH(8)) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .rx_rst     (rx_rst),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_err     (wr_err),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_err     (rd_err),
        .empty      (empty),
        .full       (full),
        .level      (level),
        .thresh_irq (thresh_irq),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr),
        .err_cnt    (err_cnt),
        .err_clr    (err_clr)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic       fl;
        logic       wv;
        logic [7:0] wd;
        logic       we;
        logic       re;
        logic       oc;
        logic       ec;
        int         x_lvl;
        logic [7:0] x_rdd;
        logic       x_rde;
        logic       x_ovr;
        logic [7:0] x_ecnt;
    } vec_t;

    vec_t vecs[19];
    logic [7:0] model_q[$];

    function automatic vec_t mk(input logic fl, input logic wv, input logic [7:0] wd,
                                input logic we, input logic re, input logic ec,
                                input int lvl, input logic [7:0] rdd, input logic rde,
                                input logic [7:0] ecnt);
        vec_t v;
        v.fl = fl; v.wv = wv; v.wd = wd; v.we = we; v.re = re; v.oc = 1'b0; v.ec = ec;
        v.x_lvl = lvl; v.x_rdd = rdd; v.x_rde = rde; v.x_ovr = 1'b0; v.x_ecnt = ecnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        rx_rst = 0; wr_valid = 0; wr_data = 0; wr_err = 0;
        rd_en = 0; ovr_clr = 0; err_clr = 0;
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
        idle();
    endtask

    task automatic push(input logic [7:0] d, input logic e, input logic pop);
        wr_valid = 1; wr_data = d; wr_err = e; rd_en = pop;
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " level"}, level, 0);
        check({tag, " empty"}, empty, 1);
        check({tag, " full"}, full, 0);
        check({tag, " thresh"}, thresh_irq, 0);
        check({tag, " overrun"}, overrun, 0);
        check({tag, " err_cnt"}, err_cnt, 0);
        check({tag, " rd_data"}, rd_data, 0);
        check({tag, " rd_err"}, rd_err, 0);
    endtask

    initial begin
        idle();
        PRESET = 1;
        #12;
        check_reset_outputs("reset");
        PRESET = 0;
        step();

        // Directed vectors: fl wv wd we re ec | level rd_data rd_err err_cnt
        vecs[0]  = mk(0, 1, 8'hA5, 0, 1, 0, 1, 8'hA5, 0, 0);
        vecs[1]  = mk(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0);
        vecs[2]  = mk(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0);
        vecs[3]  = mk(0, 1, 8'h11, 1, 0, 0, 1, 8'h11, 1, 1);
        vecs[4]  = mk(0, 1, 8'h22, 1, 0, 0, 2, 8'h11, 1, 2);
        vecs[5]  = mk(0, 1, 8'h33, 1, 0, 0, 3, 8'h11, 1, 3);
        vecs[6]  = mk(0, 1, 8'h44, 0, 0, 0, 4, 8'h11, 1, 3);
        vecs[7]  = mk(0, 0, 8'h00, 0, 1, 0, 3, 8'h22, 1, 3);
        vecs[8]  = mk(0, 0, 8'h00, 0, 1, 0, 2, 8'h33, 1, 3);
        vecs[9]  = mk(0, 0, 8'h00, 0, 1, 0, 1, 8'h44, 0, 3);
        vecs[10] = mk(0, 1, 8'h55, 1, 0, 1, 2, 8'h44, 0, 1);
        vecs[11] = mk(0, 1, 8'h66, 0, 1, 0, 2, 8'h55, 1, 1);
        vecs[12] = mk(0, 0, 8'h00, 0, 0, 1, 2, 8'h55, 1, 0);
        vecs[13] = mk(0, 1, 8'h77, 0, 0, 0, 3, 8'h55, 1, 0);
        vecs[14] = mk(0, 1, 8'h78, 1, 0, 0, 4, 8'h55, 1, 1);
        vecs[15] = mk(0, 1, 8'h79, 0, 0, 0, 5, 8'h55, 1, 1);
        vecs[16] = mk(1, 1, 8'h99, 1, 1, 0, 0, 8'h00, 0, 0);
        vecs[17] = mk(0, 1, 8'h5A, 0, 0, 0, 1, 8'h5A, 0, 0);
        vecs[18] = mk(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0);

        for (int i = 0; i < 19; i++) begin
            rx_rst = vecs[i].fl; wr_valid = vecs[i].wv; wr_data = vecs[i].wd;
            wr_err = vecs[i].we; rd_en = vecs[i].re; ovr_clr = vecs[i].oc;
            err_clr = vecs[i].ec;
            step();
            check($sformatf("v%0d level", i), level, vecs[i].x_lvl);
            check($sformatf("v%0d rd_data", i), rd_data, vecs[i].x_rdd);
            check($sformatf("v%0d rd_err", i), rd_err, vecs[i].x_rde);
            check($sformatf("v%0d err_cnt", i), err_cnt, vecs[i].x_ecnt);
            check($sformatf("v%0d overrun", i), overrun, vecs[i].x_ovr);
            check($sformatf("v%0d empty", i), empty, vecs[i].x_lvl == 0);
        end

        // Fill past full: 17 pushes, threshold and full edges, 17th dropped.
        for (int k = 1; k <= 17; k++) begin
            push(8'(k - 1), 0, 0);
            if (k <= 16) begin
                model_q.push_back(8'(k - 1));
                check($sformatf("fill%0d level", k), level, k);
                check($sformatf("fill%0d thresh", k), thresh_irq, k >= 8);
                check($sformatf("fill%0d full", k), full, k == 16);
                check($sformatf("fill%0d overrun", k), overrun, 0);
            end else begin
                check("fill17 level", level, 16);
                check("fill17 overrun", overrun, 1);
            end
        end

        // Set beats clear on a second dropped push; clear alone then works.
        wr_valid = 1; wr_data = 8'hCC; ovr_clr = 1;
        step();
        check("ovr set+clr", overrun, 1);
        ovr_clr = 1;
        step();
        check("ovr clr", overrun, 0);
        check("ovr clr level", level, 16);

        // Full push+pop: oldest leaves, new one queued last, level holds at DEPTH.
        push(8'hEE, 0, 1);
        void'(model_q.pop_front());
        model_q.push_back(8'hEE);
        check("fullpp level", level, 16);
        check("fullpp overrun", overrun, 0);
        check("fullpp full", full, 1);

        for (int k = 0; k < 16; k++) begin
            check($sformatf("drain%0d rd_data", k), rd_data, model_q[k]);
            rd_en = 1;
            step();
        end
        check("drain empty", empty, 1);
        check("drain rd_data", rd_data, 0);

        // Error counter saturation with a pop on every push.
        rx_rst = 1;
        step();
        for (int k = 0; k < 300; k++) begin
            push(8'(k), 1, 1);
        end
        check("sat err_cnt", err_cnt, 255);
        check("sat level", level, 1);
        check("sat rd_err", rd_err, 1);

        // Asynchronous reset in the middle of a burst.
        push(8'h01, 1, 0);
        push(8'h02, 0, 0);
        wr_valid = 1; wr_data = 8'h03;
        #2;
        PRESET = 1;
        #1;
        check_reset_outputs("areset");
        #3;
        PRESET = 0;
        idle();
        step();
        push(8'h3C, 0, 0);
        check("post reset level", level, 1);
        check("post reset rd_data", rd_data, 8'h3C);
        check("post reset empty", empty, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
